// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register responder: opcodes and FSM states.
package uart_reg_pkg;

  localparam logic [7:0] OP_WR = 8'hAA;
  localparam logic [7:0] OP_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_ADDR    = 3'd1,
    WR_DATA    = 3'd2,
    RD_ADDR    = 3'd3,
    TX_SEND    = 3'd4,
    TX_WAIT_HI = 3'd5,
    TX_WAIT_LO = 3'd6
  } state_t;

endpackage

// File: rtl/uart_reg_file.sv
// Register file: synchronous write, combinational read.
// Registers 0 and 1 have their own reset values and are exported live.
module uart_reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] REG0_RST = 8'h81,
  parameter logic [DATA_WIDTH-1:0] REG1_RST = 8'h20
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] reg0,
  output logic [DATA_WIDTH-1:0] reg1
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage: reset loads the per-register defaults, otherwise one write per cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 0)      mem[i] <= REG0_RST;
        else if (i == 1) mem[i] <= REG1_RST;
        else             mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
  assign reg0  = mem[0];
  assign reg1  = mem[1];

endmodule

// File: rtl/uart_reg_responder.sv
// Command responder: parses write (AA,addr,data) and read (BB,addr) frames
// from the UART receive path and answers reads through the transmit path.
//
// Handshakes:
//   rx: rx_valid is a one-cycle strobe; rx_data is taken only in that cycle.
//       Bytes arriving while a reply is being sent are dropped.
//   tx: tx_valid is a one-cycle request raised only while tx_busy=0; the
//       transmitter acknowledges by raising tx_busy and finishes by dropping
//       it. tx_data is held from the request until the FSM is back in IDLE.
module uart_reg_responder
  import uart_reg_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter logic [DATA_WIDTH-1:0] REG0_RST = 8'h81,
  parameter logic [DATA_WIDTH-1:0] REG1_RST = 8'h20,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] cfg_0,
  output logic [DATA_WIDTH-1:0] cfg_1,
  output logic                  cmd_err,
  output logic [2:0]            fsm_state
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [CNT_W-1:0]      cnt;
  logic                  cmd_err_q;

  logic                  we;
  logic                  load_tx;
  logic                  err_set;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic [DATA_WIDTH-1:0] rf_rdata;

  uart_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG0_RST   (REG0_RST),
    .REG1_RST   (REG1_RST)
  ) u_reg_file (
    .CLK   (CLK),
    .RST   (RST),
    .we    (we),
    .waddr (addr_q),
    .wdata (rx_data),
    .raddr (rx_data[ADDR_WIDTH-1:0]),
    .rdata (rf_rdata),
    .reg0  (cfg_0),
    .reg1  (cfg_1)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and control decode. Upper address bits are ignored so
  // addresses wrap; the busy check in TX_WAIT_HI wins over the timeout.
  always_comb begin
    next_state = state;
    tx_valid   = 1'b0;
    we         = 1'b0;
    load_tx    = 1'b0;
    err_set    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == DATA_WIDTH'(OP_WR))      next_state = WR_ADDR;
          else if (rx_data == DATA_WIDTH'(OP_RD)) next_state = RD_ADDR;
          else                                    err_set    = 1'b1;
        end
      end
      WR_ADDR: begin
        if (rx_valid) next_state = WR_DATA;
      end
      WR_DATA: begin
        if (rx_valid) begin
          we         = 1'b1;
          next_state = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          load_tx    = 1'b1;
          next_state = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_busy) begin
          tx_valid   = 1'b1;
          cnt_clr    = 1'b1;
          next_state = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (tx_busy) begin
          next_state = TX_WAIT_LO;
        end else if (cnt == CNT_MAX) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      TX_WAIT_LO: begin
        if (!tx_busy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: write address, reply byte, busy timeout, error pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q    <= '0;
      tx_data_q <= '0;
      cnt       <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      if (state == WR_ADDR && rx_valid) addr_q <= rx_data[ADDR_WIDTH-1:0];
      if (load_tx) tx_data_q <= rf_rdata;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      cmd_err_q <= err_set;
    end
  end

  assign tx_data   = tx_data_q;
  assign cmd_err   = cmd_err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Bench for uart_reg_responder: directed frames plus a short random
// write/read mix, with read replies checked against an expected queue.
module tb_uart_reg_responder;
  import uart_reg_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int T  = 255;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_busy;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [DW-1:0] cfg_0, cfg_1;
  logic          cmd_err;
  logic [2:0]    fsm_state;

  int vectors     = 0;
  int miscompares = 0;
  int tx_pulses   = 0;
  int err_pulses  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [8];

  uart_reg_responder #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .REG0_RST     (8'h81),
    .REG1_RST     (8'h20),
    .BUSY_TIMEOUT (T)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_busy   (tx_busy),
    .cfg_0     (cfg_0),
    .cfg_1     (cfg_1),
    .cmd_err   (cmd_err),
    .fsm_state (fsm_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = '0;
    model[0] = 8'h81;
    model[1] = 8'h20;
  endtask

  // Drivers: called at a negedge, return at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    model[a[2:0]] = d;
    check("wr_cfg_0", cfg_0, model[0]);
    check("wr_cfg_1", cfg_1, model[1]);
    check("wr_idle", fsm_state, IDLE);
  endtask

  task automatic do_read(input logic [7:0] a);
    int p0;
    p0 = tx_pulses;
    exp_q.push_back(model[a[2:0]]);
    send_byte(8'hBB);
    send_byte(a);
    check("rd_tx_valid", tx_valid, 1'b1);
    check("rd_tx_data", tx_data, model[a[2:0]]);
    @(negedge CLK);
    tx_busy = 1'b1;
    repeat (10) @(negedge CLK);
    tx_busy = 1'b0;
    repeat (2) @(negedge CLK);
    check("rd_pulses", tx_pulses - p0, 1);
    check("rd_idle", fsm_state, IDLE);
  endtask

  // Scoreboard monitor: every tx_valid must match the queue head.
  always @(negedge CLK) begin
    #1;
    if (tx_valid) begin
      tx_pulses++;
      if (exp_q.size() == 0) check("tx_spurious", tx_valid, 1'b0);
      else                   check("tx_sb", tx_data, exp_q.pop_front());
    end
    if (cmd_err) err_pulses++;
  end

  initial begin
    int e0, p0, k;
    logic [7:0] a;
    RST = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Reset state
    check("rst_cfg_0", cfg_0, 8'h81);
    check("rst_cfg_1", cfg_1, 8'h20);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_state", fsm_state, IDLE);

    // Write and read back
    do_write(8'h01, 8'h5A);
    check("wr1_cfg_1", cfg_1, 8'h5A);
    do_write(8'h03, 8'hC3);
    do_read(8'h03);

    // Address wrap
    do_write(8'hF9, 8'h11);
    check("wrap_cfg_1", cfg_1, 8'h11);
    do_read(8'h01);

    // Unknown opcode
    e0 = err_pulses;
    send_byte(8'h55);
    check("unk_err_hi", cmd_err, 1'b1);
    check("unk_state", fsm_state, IDLE);
    @(negedge CLK);
    check("unk_err_lo", cmd_err, 1'b0);
    check("unk_err_cnt", err_pulses - e0, 1);

    // Byte dropped during TX_WAIT_LO
    exp_q.push_back(model[3]);
    send_byte(8'hBB);
    send_byte(8'h03);
    @(negedge CLK);
    tx_busy = 1'b1;
    @(negedge CLK);
    check("drop_wait_lo", fsm_state, TX_WAIT_LO);
    send_byte(8'hAA);
    repeat (3) @(negedge CLK);
    tx_busy = 1'b0;
    @(negedge CLK);
    check("drop_idle", fsm_state, IDLE);
    do_write(8'h00, 8'h7E);
    check("drop_cfg_0", cfg_0, 8'h7E);

    // Busy already high when the reply is ready: hold in TX_SEND
    p0 = tx_pulses;
    exp_q.push_back(model[1]);
    tx_busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h01);
    check("hold_tx_valid", tx_valid, 1'b0);
    check("hold_state", fsm_state, TX_SEND);
    @(negedge CLK);
    check("hold_state2", fsm_state, TX_SEND);
    tx_busy = 1'b0;
    @(negedge CLK);
    tx_busy = 1'b1;
    repeat (3) @(negedge CLK);
    tx_busy = 1'b0;
    repeat (2) @(negedge CLK);
    check("hold_pulses", tx_pulses - p0, 1);
    check("hold_idle", fsm_state, IDLE);

    // Timeout with tx_busy never rising
    e0 = err_pulses;
    exp_q.push_back(model[0]);
    send_byte(8'hBB);
    send_byte(8'h00);
    check("to_tx_valid", tx_valid, 1'b1);
    k = 0;
    while (!cmd_err && k < T + 20) begin
      @(negedge CLK);
      k++;
    end
    check("to_latency", k, T + 2);
    check("to_state", fsm_state, IDLE);
    @(negedge CLK);
    check("to_err_cnt", err_pulses - e0, 1);
    check("to_err_lo", cmd_err, 1'b0);

    // tx_busy rising in the last counted cycle is a success
    e0 = err_pulses;
    exp_q.push_back(model[0]);
    send_byte(8'hBB);
    send_byte(8'h00);
    repeat (T + 1) @(negedge CLK);
    check("bnd_pre_state", fsm_state, TX_WAIT_HI);
    tx_busy = 1'b1;
    @(negedge CLK);
    check("bnd_state", fsm_state, TX_WAIT_LO);
    check("bnd_err", cmd_err, 1'b0);
    repeat (3) @(negedge CLK);
    tx_busy = 1'b0;
    repeat (2) @(negedge CLK);
    check("bnd_idle", fsm_state, IDLE);
    check("bnd_err_cnt", err_pulses - e0, 0);

    // Reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h02);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    e0 = err_pulses;
    send_byte(8'h33);
    check("mrst_err", cmd_err, 1'b1);
    check("mrst_cfg_0", cfg_0, 8'h81);
    check("mrst_state", fsm_state, IDLE);
    @(negedge CLK);
    check("mrst_err_cnt", err_pulses - e0, 1);
    do_read(8'h02);

    // Random write/read mix
    repeat (6) begin
      a = 8'($urandom_range(0, 255));
      do_write(a, 8'($urandom_range(0, 255)));
    end
    repeat (4) begin
      a = 8'($urandom_range(0, 255));
      do_read(a);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
